// File: rtl/cdc_handshake_rx.sv
// Destination-domain endpoint of a toggle req/ack handshake. It waits a settle time after
// each request edge, captures the word, offers it on valid/ready, and toggles ack on accept.
module cdc_handshake_rx #(
  parameter int W          = 8,
  parameter int SETTLE_CYC = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_sync,
  input  logic [W-1:0] data_sync,
  input  logic         ready,
  input  logic         clr_overrun,
  output logic [W-1:0] data_out,
  output logic         valid,
  output logic         ack_tog,
  output logic         overrun,
  output logic         busy
);

  localparam int CW = (SETTLE_CYC < 1) ? 1 : $clog2(SETTLE_CYC + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYC);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } state_t;

  state_t        state, state_nx;
  logic          req_prev, req_prev_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [W-1:0]  data_nx;
  logic          valid_nx, ack_nx, overrun_nx;
  logic          req_edge;

  // An edge stays visible until IDLE consumes it, so a mismatch raised mid-transfer
  // becomes the next request instead of being lost.
  assign req_edge = req_sync ^ req_prev;
  assign busy     = (state != IDLE);

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    state_nx    = state;
    req_prev_nx = req_prev;
    cnt_nx      = cnt;
    data_nx     = data_out;
    valid_nx    = valid;
    ack_nx      = ack_tog;
    overrun_nx  = overrun;

    case (state)
      IDLE: begin
        if (req_edge) begin
          req_prev_nx = req_sync;
          cnt_nx      = CNT_LOAD;
          state_nx    = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt == '0) begin
          data_nx  = data_sync;
          valid_nx = 1'b1;
          state_nx = HOLD;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      HOLD: begin
        if (valid && ready) begin
          valid_nx = 1'b0;
          ack_nx   = ~ack_tog;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase

    // A new violation outranks a simultaneous clear.
    if ((state != IDLE) && req_edge) begin
      overrun_nx = 1'b1;
    end else if (clr_overrun) begin
      overrun_nx = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      req_prev <= 1'b0;
      cnt      <= '0;
      data_out <= '0;
      valid    <= 1'b0;
      ack_tog  <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_nx;
      req_prev <= req_prev_nx;
      cnt      <= cnt_nx;
      data_out <= data_nx;
      valid    <= valid_nx;
      ack_tog  <= ack_nx;
      overrun  <= overrun_nx;
    end
  end

endmodule

// File: tb/tb_cdc_handshake_rx.sv
// Bench for cdc_handshake_rx: directed vectors on a SETTLE_CYC=2 instance, reset corner cases,
// and randomized traffic on SETTLE_CYC=0 and 2 instances against a transfer-level model.
module tb_cdc_handshake_rx;

  logic       clk, rst, req, ready, clr;
  logic [7:0] data;

  logic [7:0] d0, d2;
  logic       v0, a0, o0, b0, v2, a2, o2, b2;

  int checks   = 0;
  int failures = 0;

  cdc_handshake_rx #(.W(8), .SETTLE_CYC(0)) u0 (
    .clk(clk), .rst(rst), .req_sync(req), .data_sync(data), .ready(ready), .clr_overrun(clr),
    .data_out(d0), .valid(v0), .ack_tog(a0), .overrun(o0), .busy(b0)
  );

  cdc_handshake_rx #(.W(8), .SETTLE_CYC(2)) u2 (
    .clk(clk), .rst(rst), .req_sync(req), .data_sync(data), .ready(ready), .clr_overrun(clr),
    .data_out(d2), .valid(v2), .ack_tog(a2), .overrun(o2), .busy(b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observation word layout: {busy, overrun, ack_tog, valid, data_out}
  function automatic logic [11:0] pk(logic b, logic o, logic a, logic v, logic [7:0] d);
    return {b, o, a, v, d};
  endfunction

  wire [11:0] obs0 = {b0, o0, a0, v0, d0};
  wire [11:0] obs2 = {b2, o2, a2, v2, d2};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Vector: inputs applied before a posedge, expected outputs after it.
  typedef struct {
    logic       req;
    logic [7:0] data;
    logic       rdy;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [7:0] dt, input logic rd,
                     input logic b, input logic a, input logic v, input logic [7:0] dq);
    vec_t x;
    x.req  = r;
    x.data = dt;
    x.rdy  = rd;
    x.exp  = pk(b, 1'b0, a, v, dq);
    tbl.push_back(x);
  endtask

  // Transfer-level model: a transfer opens when the request level differs from the last
  // accepted level, the word is captured at detect+S+1, and it closes on the accepting edge.
  typedef struct {
    bit         active;
    bit         valid;
    bit         ack;
    bit         ovr;
    bit         level;
    logic [7:0] data;
    int         cap_at;
  } model_t;

  function automatic model_t model_clear();
    model_t z;
    z.active = 0; z.valid = 0; z.ack = 0; z.ovr = 0; z.level = 0;
    z.data = 8'h00; z.cap_at = 0;
    return z;
  endfunction

  function automatic model_t model_step(model_t x, int s, bit r, logic [7:0] dt,
                                        bit rd, bit cl, int now);
    model_t y = x;
    bit pending = (r != x.level);
    if (!x.active) begin
      if (pending) begin
        y.active = 1;
        y.level  = r;
        y.cap_at = now + s + 1;
      end
    end else if (!x.valid) begin
      if (now == x.cap_at) begin
        y.valid = 1;
        y.data  = dt;
      end
    end else if (rd) begin
      y.valid  = 0;
      y.ack    = ~x.ack;
      y.active = 0;
    end
    if (x.active && pending) y.ovr = 1;
    else if (cl)             y.ovr = 0;
    return y;
  endfunction

  model_t m0, m2;
  int     cyc;
  logic [7:0] words [3];

  initial begin
    rst = 1'b0; req = 1'b0; ready = 1'b0; clr = 1'b0; data = 8'h00;
    words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03;

    // Asynchronous reset mid-cycle, before any clock edge
    #2 rst = 1'b1;
    #1;
    check("async_reset_s0", obs0, 12'h000);
    check("async_reset_s2", obs2, 12'h000);
    @(negedge clk);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_s0", obs0, 12'h000);
      check("idle_s2", obs2, 12'h000);
    end

    // Reset while the SETTLE_CYC=0 instance sits in HOLD
    req = 1'b1; ready = 1'b0; data = 8'h99;
    tick();
    check("mid_detect_busy_s0", b0, 1'b1);
    tick();
    check("mid_hold_s0", obs0, pk(1, 0, 0, 1, 8'h99));
    #2 rst = 1'b1;
    #1;
    check("mid_reset_s0", obs0, 12'h000);
    check("mid_reset_s2", obs2, 12'h000);
    req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("post_reset_s0", obs0, 12'h000);
    check("post_reset_s2", obs2, 12'h000);

    // Basic transfer then backpressure, SETTLE_CYC=2
    repeat (3) add(1, 8'hA5, 1, 1, 0, 0, 8'h00);
    add(1, 8'hA5, 1, 1, 0, 1, 8'hA5);
    repeat (2) add(1, 8'hA5, 1, 0, 1, 0, 8'hA5);
    repeat (3) add(0, 8'hA5, 0, 1, 1, 0, 8'hA5);
    add(0, 8'hA5, 0, 1, 1, 1, 8'hA5);
    repeat (10) add(0, 8'h3C, 0, 1, 1, 1, 8'hA5);
    add(0, 8'h3C, 1, 0, 0, 0, 8'hA5);
    foreach (tbl[i]) begin
      req = tbl[i].req; data = tbl[i].data; ready = tbl[i].rdy; clr = 1'b0;
      tick();
      check($sformatf("vec%0d", i), obs2, tbl[i].exp);
    end

    // Back-to-back transfers with ready high: valid every 5 cycles
    ready = 1'b1;
    for (int k = 0; k < 15; k++) begin
      if (k % 5 == 0) begin
        req  = ~req;
        data = words[k / 5];
      end
      tick();
      check($sformatf("b2b_valid%0d", k), v2, (k % 5 == 3));
      if (k % 5 == 3) check($sformatf("b2b_data%0d", k), d2, words[k / 5]);
      if (k % 5 == 4) check($sformatf("b2b_ack%0d", k), a2, ((k / 5) % 2 == 0));
    end
    check("b2b_overrun", o2, 1'b0);
    check("b2b_idle", b2, 1'b0);

    // Overrun during HOLD, pending edge restarts after accept, clear behaviour
    ready = 1'b0; req = ~req; data = 8'h5A;
    repeat (4) tick();
    check("ovr_first_valid", obs2, pk(1, 0, 1, 1, 8'h5A));
    req = ~req; data = 8'h66;
    tick();
    check("ovr_set", obs2, pk(1, 1, 1, 1, 8'h5A));
    ready = 1'b1;
    tick();
    check("ovr_first_accept", obs2, pk(0, 1, 0, 0, 8'h5A));
    ready = 1'b0;
    tick();
    check("ovr_second_start", b2, 1'b1);
    req = ~req; clr = 1'b1;
    tick();
    check("ovr_clr_vs_set", o2, 1'b1);
    clr = 1'b0;
    repeat (2) tick();
    check("ovr_second_valid", obs2, pk(1, 1, 0, 1, 8'h66));
    ready = 1'b1;
    tick();
    check("ovr_second_accept", obs2, pk(0, 1, 1, 0, 8'h66));
    data = 8'h77;
    tick();
    check("ovr_third_start", b2, 1'b1);
    repeat (3) tick();
    check("ovr_third_valid", obs2, pk(1, 1, 1, 1, 8'h77));
    tick();
    check("ovr_third_accept", obs2, pk(0, 1, 0, 0, 8'h77));
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("ovr_cleared", o2, 1'b0);

    // Randomized traffic against the model on both instances
    rst = 1'b1;
    tick();
    rst = 1'b0; req = 1'b0; ready = 1'b0; clr = 1'b0;
    m0 = model_clear();
    m2 = model_clear();
    cyc = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(3) == 0) req = ~req;
      data  = 8'($urandom);
      ready = ($urandom_range(1) == 1);
      clr   = ($urandom_range(7) == 0);
      m0 = model_step(m0, 0, req, data, ready, clr, cyc);
      m2 = model_step(m2, 2, req, data, ready, clr, cyc);
      tick();
      cyc++;
      check($sformatf("rand_s0_%0d", i), obs0, pk(m0.active, m0.ovr, m0.ack, m0.valid, m0.data));
      check($sformatf("rand_s2_%0d", i), obs2, pk(m2.active, m2.ovr, m2.ack, m2.valid, m2.data));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cdc_handshake_rx.md
# cdc_handshake_rx

Receive-side endpoint of the toggle req/ack handshake used to move multi-bit words, such as DDS frequency and phase words, between clock domains. It runs entirely in the destination clock domain. Its request toggle and data bus arrive already synchronized by `cdc_generic` instances, and it returns an ack toggle that the source side synchronizes back. It waits a programmable settle time after each request edge, captures the word, presents it on a valid/ready interface to the local consumer, and acknowledges once the word is accepted.

## Interface
Parameters:
- `W`, default 8: data word width, 1..64.
- `SETTLE_CYC`, default 2: extra destination cycles to wait after request-edge detection before sampling `data_sync`, 0..255. Set this to at least the data-path synchronizer depth.

Ports:
- `clk` in 1: destination clock; the only clock in the block.
- `rst` in 1: reset, asynchronous and active-high.
- `req_sync` in 1: request toggle, already synchronized to `clk`; each level change is one transfer request.
- `data_sync` in W: data word, already synchronized to `clk`; the sender holds it stable from its req toggle until it sees `ack_tog`.
- `ready` in 1: consumer accepts `data_out` when `ready` and `valid` are both high.
- `clr_overrun` in 1: synchronous clear of `overrun`.
- `data_out` out W: captured word; held stable while `valid` is high.
- `valid` out 1: captured word available.
- `ack_tog` out 1: acknowledge toggle, sent back toward the source domain through `cdc_generic`.
- `overrun` out 1: sticky flag for a request edge that arrives while a transfer is in progress.
- `busy` out 1: high in every state except IDLE.

## Operation
- Edge detection uses an internal `req_prev` register: `edge = req_sync ^ req_prev`.
- `req_prev` is updated to `req_sync` only when IDLE accepts an edge.
- States: IDLE, SETTLE, HOLD.
- IDLE: if `edge`, set `req_prev <= req_sync`, load `cnt <= SETTLE_CYC`, and go to SETTLE.
- SETTLE: if `cnt == 0`, set `data_out <= data_sync`, `valid <= 1`, and go to HOLD; otherwise `cnt <= cnt - 1`.
- HOLD: `valid` stays high and `data_out` is frozen. When `valid && ready` on a posedge: `valid <= 0`, `ack_tog <= ~ack_tog`, go to IDLE.
- Overrun: in SETTLE or HOLD, `edge == 1` on a posedge sets `overrun <= 1`.
  - The transfer in progress is not disturbed.
  - After returning to IDLE, the pending mismatch is treated as a new request.
- `clr_overrun` clears `overrun` on the next posedge. If clear and set occur together, set wins.
- Counter width is `$clog2(SETTLE_CYC+1)`, minimum 1 bit. The counter never decrements below 0.
- `busy = (state != IDLE)`, combinational from the state register.
- Reset values: state IDLE, `req_prev` 0, `cnt` 0, `data_out` 0, `valid` 0, `ack_tog` 0, `overrun` 0, `busy` 0.
- The source-side toggle resets to 0, so no transfer is seen out of reset.
- Reset asserted mid-transfer returns the block to IDLE immediately. Any captured word is discarded and no ack is issued.

## Timing
- The edge is detected at posedge E, which means `req_sync` differs from `req_prev` at E.
- The block is in SETTLE from E+1 through E+SETTLE_CYC+1.
- `data_out` and `valid` update at posedge E+SETTLE_CYC+1, so latency from edge detection to `valid` is SETTLE_CYC+1 cycles.
  - With SETTLE_CYC = 0, `valid` rises at E+1.
- `data_sync` is sampled exactly once per transfer, at the capture posedge.
- Accept at posedge A, where `valid && ready`: `valid` falls and `ack_tog` toggles at A.
- The block is in IDLE from A; an edge present at A+1 starts the next transfer.
- `ready` held high before `valid` rises gives acceptance on the first cycle `valid` is high. HOLD then lasts exactly 1 cycle.
- Minimum transfer period is SETTLE_CYC+3 cycles when `ready` is high continuously (IDLE, SETTLE..., HOLD).
- All outputs are registered except `busy`, which is decoded directly from the state register.

## Test plan
- Reset and idle: assert `rst` asynchronously mid-cycle, with `req_sync` 0. Outputs must go to 0 immediately and stay 0 while idle; `busy` stays 0.
- Basic transfer (W=8, SETTLE_CYC=2): toggle `req_sync` 0→1 with `data_sync` = 0xA5 and `ready` = 1.
  - `valid` rises 3 cycles after the detect posedge with `data_out` = 0xA5.
  - `valid` lasts 1 cycle and `ack_tog` goes 0→1 on the same edge.
- Backpressure: hold `ready` at 0 for 10 cycles after `valid` rises, changing `data_sync` to 0x3C meanwhile.
  - `data_out` must stay 0xA5 and `valid` must stay high.
  - `ack_tog` toggles only on the cycle `ready` goes high.
- Back-to-back transfers: send 0x01, 0x02, 0x03 with `ready` high. Expect three `valid` pulses 5 cycles apart with the correct data, `ack_tog` toggling 1, 0, 1, and `overrun` staying 0.
- Overrun and clear: toggle `req_sync` again during HOLD.
  - `overrun` sets, and the first word still completes.
  - A second transfer starts the cycle after accept.
  - `clr_overrun` pulsed concurrently with a new violation leaves `overrun` at 1; pulsed alone, it clears `overrun` to 0.
- Reset mid-transfer (SETTLE_CYC=0): assert `rst` while in HOLD. `valid` drops and `ack_tog` stays unchanged at reset value 0; after release, the block is in IDLE with `busy` at 0.
